// File: rtl/test_core_if.sv
// Control/result bundle for the test_core recognition engine.
// The core drives the result side; the requester drives start.
interface test_core_if;
    logic       start;
    logic       result_ack;
    logic [5:0] result;
    logic       overflow;
    logic       fft_finish;

    modport master (
        output start,
        input  result_ack,
        input  result,
        input  overflow,
        input  fft_finish
    );

    modport slave (
        input  start,
        output result_ack,
        output result,
        output overflow,
        output fft_finish
    );
endinterface

// File: rtl/test_core.sv
// Isolated-word recognition core: builds an internal test frame, reduces it to
// band energies and picks the closest ROM template by sum of absolute differences.
module test_core #(
    parameter int unsigned N_SAMPLES   = 16,
    parameter int unsigned N_FEAT      = 4,
    parameter int unsigned N_TEMPL     = 4,
    parameter int unsigned SAMPLE_STEP = 16,
    parameter int unsigned THRESH      = 64
) (
    input  logic        clk,
    input  logic        reset,
    test_core_if.slave  bus
);

    localparam int unsigned BAND_LEN  = N_SAMPLES / N_FEAT;
    localparam int unsigned MATCH_LEN = N_TEMPL * N_FEAT;
    localparam int unsigned FEAT_W    = 10;
    localparam int unsigned DIST_W    = 12;
    localparam int unsigned CNT_MAX   = (N_SAMPLES > MATCH_LEN) ? N_SAMPLES : MATCH_LEN;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
    localparam int unsigned POS_W     = (BAND_LEN > 1) ? $clog2(BAND_LEN) : 1;
    localparam int unsigned FI_W      = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
    localparam int unsigned TI_W      = (N_TEMPL > 1) ? $clog2(N_TEMPL) : 1;
    localparam int unsigned ROM_DIM   = 4;

    localparam logic [FEAT_W-1:0] FEAT_MAX = '1;
    localparam logic [DIST_W-1:0] DIST_MAX = '1;

    localparam logic [FEAT_W-1:0] T_ROM [ROM_DIM][ROM_DIM] = '{
        '{10'd0,   10'd0,   10'd0,   10'd0  },
        '{10'd400, 10'd150, 10'd100, 10'd350},
        '{10'd512, 10'd512, 10'd512, 10'd512},
        '{10'd100, 10'd300, 10'd300, 10'd100}
    };

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GEN   = 2'd1,
        S_MATCH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic                r_start_q;
    logic [CNT_W-1:0]    r_cnt;
    logic [7:0]          r_x;
    logic [POS_W-1:0]    r_pos;
    logic [FI_W-1:0]     r_band;
    logic [FEAT_W-1:0]   r_feat [N_FEAT];
    logic                r_sat;
    logic [FI_W-1:0]     r_fk;
    logic [TI_W-1:0]     r_tj;
    logic [FEAT_W-1:0]   r_diff;
    logic                r_diff_vld;
    logic                r_diff_last;
    logic [TI_W-1:0]     r_diff_tj;
    logic [DIST_W-1:0]   r_dist;
    logic [DIST_W-1:0]   r_best_dist;
    logic [TI_W-1:0]     r_best_idx;
    logic                r_pub;
    logic                r_ack;
    logic [5:0]          r_result;
    logic                r_overflow;
    logic                r_finish;

    logic                w_accept;
    logic                w_gen_last;
    logic                w_match_last;
    logic [7:0]          w_a;
    logic [FEAT_W:0]     w_feat_sum;
    logic [FEAT_W-1:0]   w_feat_sat;
    logic                w_feat_ovf;
    logic [FEAT_W-1:0]   w_tval;
    logic [FEAT_W-1:0]   w_fcur;
    logic [FEAT_W-1:0]   w_diff;
    logic [DIST_W:0]     w_dist_sum;
    logic [DIST_W-1:0]   w_dist_sat;
    logic                w_dist_ovf;

    // A new run is only accepted while no run is in flight.
    assign w_accept     = bus.start && !r_start_q && (r_state == S_IDLE || r_state == S_DONE);
    assign w_gen_last   = (r_cnt == CNT_W'(N_SAMPLES - 1));
    assign w_match_last = (r_cnt == CNT_W'(MATCH_LEN));

    always_comb begin
        w_a        = (r_x >= 8'd128) ? (r_x - 8'd128) : (8'd128 - r_x);
        w_feat_sum = (FEAT_W+1)'(r_feat[r_band]) + (FEAT_W+1)'(w_a);
        w_feat_ovf = w_feat_sum[FEAT_W];
        w_feat_sat = w_feat_ovf ? FEAT_MAX : w_feat_sum[FEAT_W-1:0];

        w_tval = '0;
        if (32'(r_tj) < ROM_DIM && 32'(r_fk) < ROM_DIM)
            w_tval = T_ROM[2'(r_tj)][2'(r_fk)];
        w_fcur = r_feat[r_fk];
        w_diff = (w_fcur >= w_tval) ? (w_fcur - w_tval) : (w_tval - w_fcur);

        w_dist_sum = (DIST_W+1)'(r_dist) + (DIST_W+1)'(r_diff);
        w_dist_ovf = w_dist_sum[DIST_W];
        w_dist_sat = w_dist_ovf ? DIST_MAX : w_dist_sum[DIST_W-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)     w_next = S_GEN;
            S_GEN:   if (w_gen_last)   w_next = S_MATCH;
            S_MATCH: if (w_match_last) w_next = S_DONE;
            S_DONE:  if (w_accept)     w_next = S_GEN;
            default:                   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_start_q   <= 1'b0;
            r_cnt       <= '0;
            r_x         <= '0;
            r_pos       <= '0;
            r_band      <= '0;
            for (int i = 0; i < int'(N_FEAT); i++) r_feat[i] <= '0;
            r_sat       <= 1'b0;
            r_fk        <= '0;
            r_tj        <= '0;
            r_diff      <= '0;
            r_diff_vld  <= 1'b0;
            r_diff_last <= 1'b0;
            r_diff_tj   <= '0;
            r_dist      <= '0;
            r_best_dist <= '0;
            r_best_idx  <= '0;
            r_pub       <= 1'b0;
            r_ack       <= 1'b0;
            r_result    <= '0;
            r_overflow  <= 1'b0;
            r_finish    <= 1'b0;
        end else begin
            r_start_q <= bus.start;
            r_ack     <= 1'b0;
            if (w_accept) begin
                r_cnt       <= '0;
                r_x         <= '0;
                r_pos       <= '0;
                r_band      <= '0;
                for (int i = 0; i < int'(N_FEAT); i++) r_feat[i] <= '0;
                r_sat       <= 1'b0;
                r_fk        <= '0;
                r_tj        <= '0;
                r_diff_vld  <= 1'b0;
                r_diff_last <= 1'b0;
                r_dist      <= '0;
                r_best_dist <= DIST_MAX;
                r_best_idx  <= '0;
                r_pub       <= 1'b0;
                r_finish    <= 1'b0;
            end else begin
                case (r_state)
                    S_GEN: begin
                        r_feat[r_band] <= w_feat_sat;
                        if (w_feat_ovf) r_sat <= 1'b1;
                        r_x <= r_x + 8'(SAMPLE_STEP);
                        if (r_pos == POS_W'(BAND_LEN - 1)) begin
                            r_pos  <= '0;
                            r_band <= r_band + 1'b1;
                        end else begin
                            r_pos <= r_pos + 1'b1;
                        end
                        r_cnt <= w_gen_last ? '0 : r_cnt + 1'b1;
                    end
                    S_MATCH: begin
                        // Stage 1: fetch one |feat - T| term per cycle.
                        r_diff_vld <= !w_match_last;
                        if (!w_match_last) begin
                            r_diff      <= w_diff;
                            r_diff_last <= (r_fk == FI_W'(N_FEAT - 1));
                            r_diff_tj   <= r_tj;
                            if (r_fk == FI_W'(N_FEAT - 1)) begin
                                r_fk <= '0;
                                r_tj <= r_tj + 1'b1;
                            end else begin
                                r_fk <= r_fk + 1'b1;
                            end
                        end
                        // Stage 2: accumulate, and settle the template on its last term.
                        if (r_diff_vld) begin
                            if (w_dist_ovf) r_sat <= 1'b1;
                            if (r_diff_last) begin
                                if (w_dist_sat < r_best_dist) begin
                                    r_best_dist <= w_dist_sat;
                                    r_best_idx  <= r_diff_tj;
                                end
                                r_dist <= '0;
                            end else begin
                                r_dist <= w_dist_sat;
                            end
                        end
                        if (w_match_last) r_pub <= 1'b1;
                        r_cnt <= r_cnt + 1'b1;
                    end
                    S_DONE: begin
                        if (r_pub) begin
                            r_pub      <= 1'b0;
                            r_result   <= 6'(r_best_idx);
                            r_overflow <= (r_best_dist > DIST_W'(THRESH)) || r_sat;
                            r_ack      <= 1'b1;
                            r_finish   <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.result_ack = r_ack;
    assign bus.result     = r_result;
    assign bus.overflow   = r_overflow;
    assign bus.fft_finish = r_finish;

endmodule

// File: tb/tb_test_core.sv
// Scoreboard bench for test_core: three configurations run in lockstep from one
// start/reset stream; expectations come from an arithmetic model of the algorithm.
module tb_test_core;

    localparam int NDUT = 3;
    localparam int LAT  = 34;
    localparam int CFG_STEP [NDUT] = '{16, 0, 16};
    localparam int CFG_THR  [NDUT] = '{64, 64, 16};
    localparam int TMPL [4][4] = '{
        '{0, 0, 0, 0}, '{400, 150, 100, 350}, '{512, 512, 512, 512}, '{100, 300, 300, 100}
    };

    typedef struct packed {
        int              due;
        logic [2:0][5:0] res;
        logic [2:0]      ovf;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    int   cyc   = 0;

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    test_core_if if0 ();
    test_core_if if1 ();
    test_core_if if2 ();

    assign if0.start = start;
    assign if1.start = start;
    assign if2.start = start;

    test_core u_dflt (.clk(clk), .reset(reset), .bus(if0));
    test_core #(.SAMPLE_STEP(0)) u_step0 (.clk(clk), .reset(reset), .bus(if1));
    test_core #(.THRESH(16)) u_th16 (.clk(clk), .reset(reset), .bus(if2));

    logic [2:0] ack, ovf, fin;
    logic [5:0] res [NDUT];
    assign ack    = {if2.result_ack, if1.result_ack, if0.result_ack};
    assign ovf    = {if2.overflow, if1.overflow, if0.overflow};
    assign fin    = {if2.fft_finish, if1.fft_finish, if0.fft_finish};
    assign res[0] = if0.result;
    assign res[1] = if1.result;
    assign res[2] = if2.result;

    int   n_chk = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    int   last_res [NDUT];
    int   last_ovf [NDUT];
    bit   have_last = 1'b0;
    logic [2:0] prev_ack = '0;

    task automatic chk(input string name, input int idx, input int got, input int want);
        n_chk++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s dut%0d @cycle %0d: got %0d expected %0d", name, idx, cyc, got, want);
        end
    endtask

    // Reference: band energies of the synthetic ramp, then nearest template.
    function automatic void model(input int step, input int thresh, output int r, output int o);
        int feat [4];
        int best, d, x, a, diff;
        for (int k = 0; k < 4; k++) feat[k] = 0;
        for (int n = 0; n < 16; n++) begin
            x = (n * step) % 256;
            a = (x >= 128) ? x - 128 : 128 - x;
            feat[n / 4] = feat[n / 4] + a;
            if (feat[n / 4] > 1023) feat[n / 4] = 1023;
        end
        best = 4095;
        r = 0;
        for (int j = 0; j < 4; j++) begin
            d = 0;
            for (int k = 0; k < 4; k++) begin
                diff = feat[k] - TMPL[j][k];
                d += (diff < 0) ? -diff : diff;
            end
            if (d > 4095) d = 4095;
            if (d < best) begin
                best = d;
                r = j;
            end
        end
        o = (best > thresh) ? 1 : 0;
    endfunction

    // Monitor: pops one expectation per result_ack and checks the published result.
    always @(negedge clk) begin : mon
        exp_t e;
        if (reset) begin
            if (ack != 3'b000) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_ack", 0, int'(ack), 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("ack_latency", 0, cyc, e.due);
                    for (int i = 0; i < NDUT; i++) begin
                        chk("ack_present", i, int'(ack[i]), 1);
                        chk("result", i, int'(res[i]), int'(e.res[i]));
                        chk("overflow", i, int'(ovf[i]), int'(e.ovf[i]));
                        chk("finish_with_ack", i, int'(fin[i]), 1);
                        last_res[i] = int'(e.res[i]);
                        last_ovf[i] = int'(e.ovf[i]);
                    end
                    have_last = 1'b1;
                end
            end
            for (int i = 0; i < NDUT; i++) begin
                if (ack[i]) chk("ack_single_cycle", i, int'(prev_ack[i]), 0);
                if (have_last && fin[i] && !ack[i] && exp_q.size() == 0) begin
                    chk("result_hold", i, int'(res[i]), last_res[i]);
                    chk("overflow_hold", i, int'(ovf[i]), last_ovf[i]);
                end
            end
            if (exp_q.size() != 0 && cyc > exp_q[0].due + 2) begin
                chk("ack_timeout", 0, cyc, exp_q[0].due);
                void'(exp_q.pop_front());
            end
        end
        prev_ack = ack;
    end

    task automatic push_expect();
        exp_t e;
        int r, o;
        e.due = cyc + 1 + LAT;
        for (int i = 0; i < NDUT; i++) begin
            model(CFG_STEP[i], CFG_THR[i], r, o);
            e.res[i] = 6'(r);
            e.ovf[i] = 1'(o);
        end
        exp_q.push_back(e);
    endtask

    task automatic do_run(input int hold, input bit extra);
        int n;
        @(negedge clk);
        start = 1'b1;
        push_expect();
        @(posedge clk);
        #1;
        for (int i = 0; i < NDUT; i++) begin
            chk("finish_cleared_on_accept", i, int'(fin[i]), 0);
            if (have_last) chk("result_kept_on_accept", i, int'(res[i]), last_res[i]);
        end
        repeat (hold - 1) @(negedge clk);
        if (hold <= LAT - 2) start = 1'b0;
        if (extra && hold < 25) begin
            repeat ($urandom_range(3, 1)) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        n = 0;
        while (exp_q.size() != 0 && n < LAT + 10) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) chk("run_not_completed", 0, exp_q.size(), 0);
        start = 1'b0;
        repeat ($urandom_range(4, 1)) @(negedge clk);
    endtask

    task automatic do_abort(input int when);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (when) @(negedge clk);
        #3 reset = 1'b0;
        #1;
        for (int i = 0; i < NDUT; i++) begin
            chk("abort_ack", i, int'(ack[i]), 0);
            chk("abort_result", i, int'(res[i]), 0);
            chk("abort_overflow", i, int'(ovf[i]), 0);
            chk("abort_finish", i, int'(fin[i]), 0);
        end
        exp_q.delete();
        have_last = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #30;
        for (int i = 0; i < NDUT; i++) begin
            chk("reset_ack", i, int'(ack[i]), 0);
            chk("reset_result", i, int'(res[i]), 0);
            chk("reset_overflow", i, int'(ovf[i]), 0);
            chk("reset_finish", i, int'(fin[i]), 0);
        end
        #10 reset = 1'b1;

        do_run(10, 1'b1);
        do_run(3, 1'b0);
        do_abort(5);
        do_run(2, 1'b0);
        do_run(40, 1'b0);
        do_abort(20);
        for (int t = 0; t < 12; t++) begin
            if ($urandom_range(4, 0) == 0) do_abort(int'($urandom_range(28, 0)));
            else do_run(int'($urandom_range(45, 1)), 1'($urandom_range(1, 0)));
        end
        do_run(1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got time %0t expected < 1ms", $time);
        $fatal(1);
    end

endmodule
